// File: rtl/lived_pkg.sv
// Shared types and constants for the LEGv8 memory-access stage.
//   mem_state_t : data-memory handshake FSM states
//   ex_mem_t    : EX/MEM pipeline register contents
//   mem_wb_t    : MEM/WB pipeline register contents
// The structs are sized by XLEN; mem_stage must be built with N == XLEN.
package lived_pkg;

  localparam int unsigned XLEN            = 64;
  localparam int unsigned DM_ALIGN_BITS   = 3;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            zero;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_branch;
  } ex_mem_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [4:0]      rd;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] alu_result;
  } mem_wb_t;

endpackage

// File: rtl/flopr_en_clr.sv
// N-bit pipeline register with synchronous active-low reset, synchronous clear
// and load enable. Priority: reset, then clear, then enable.
//   clk   : clock
//   reset : synchronous reset, active low
//   en    : load d when high
//   clr   : load zero when high (overrides en)
//   d, q  : data in / out
module flopr_en_clr #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory-access stage: EX/MEM register, variable-latency data-memory
// req/ack handshake with timeout, branch resolution and the MEM/WB register.
//   clk, reset                  : clock, synchronous active-low reset
//   *_E                         : instruction from execute
//   dm_req/we/addr/wdata        : request to data memory
//   dm_ack/rdata                : completion and load data from data memory
//   stall_M                     : freeze upstream stages and EX/MEM
//   PCSrc_M, PCBranch_M         : branch redirect
//   fault_M                     : sticky misaligned-access / timeout flag
//   *_W                         : MEM/WB register toward writeback
module mem_stage import lived_pkg::*; #(
  parameter int unsigned N       = XLEN,
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         RegWrite_E,
  input  logic         MemtoReg_E,
  input  logic [4:0]   rd_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         fault_M,
  output logic         RegWrite_W,
  output logic         MemtoReg_W,
  output logic [4:0]   rd_W,
  output logic [N-1:0] readData_W,
  output logic [N-1:0] aluResult_W
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  ex_mem_t    ex_d, ex_q;
  mem_wb_t    wb_d, wb_q;
  mem_state_t state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic fault_q;
  logic memop, misaligned, abort, wb_ok;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = valid_E & ~flush_E;
    ex_d.branch     = Branch_E;
    ex_d.mem_read   = MemRead_E;
    ex_d.mem_write  = MemWrite_E;
    ex_d.reg_write  = RegWrite_E;
    ex_d.mem_to_reg = MemtoReg_E;
    ex_d.zero       = zero_E;
    ex_d.rd         = rd_E;
    ex_d.alu_result = aluResult_E;
    ex_d.write_data = writeData_E;
    ex_d.pc_branch  = PCBranch_E;
  end

  flopr_en_clr #(.N($bits(ex_mem_t))) u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_M),
    .clr   (1'b0),
    .d     (ex_d),
    .q     (ex_q)
  );

  // Handshake FSM. In WAIT the EX/MEM register is frozen by stall_M, so the
  // address/data/we driven from it stay stable without extra holding flops.
  always_comb begin
    memop      = ex_q.valid & (ex_q.mem_read | ex_q.mem_write);
    misaligned = memop & (ex_q.alu_result[DM_ALIGN_BITS-1:0] != '0);
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req     = 1'b0;
    stall_M    = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop && !misaligned) begin
          dm_req = 1'b1;
          if (!dm_ack) begin
            stall_M = 1'b1;
            state_d = WAIT;
            cnt_d   = CntW'(1);
          end
        end
      end
      WAIT: begin
        // A late ack still wins over the timeout on the same cycle.
        if (dm_ack) begin
          dm_req  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CntW'(TIMEOUT)) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          dm_req  = 1'b1;
          stall_M = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_q | misaligned | abort;
    end
  end

  always_comb begin
    dm_we      = dm_req & ex_q.mem_write;
    dm_addr    = ex_q.alu_result;
    dm_wdata   = ex_q.write_data;
    PCSrc_M    = ex_q.valid & ex_q.branch & ex_q.zero & ~stall_M;
    PCBranch_M = ex_q.pc_branch;
    fault_M    = fault_q;
  end

  // Anything that is not a finished instruction retires as an all-zero bubble.
  always_comb begin
    wb_ok         = ex_q.valid & ~stall_M & ~abort & ~misaligned;
    wb_d          = '0;
    wb_d.reg_write  = ex_q.reg_write;
    wb_d.mem_to_reg = ex_q.mem_to_reg;
    wb_d.rd         = ex_q.rd;
    wb_d.alu_result = ex_q.alu_result;
    wb_d.read_data  = (ex_q.mem_read & ~ex_q.mem_write) ? dm_rdata : '0;
  end

  flopr_en_clr #(.N($bits(mem_wb_t))) u_mem_wb (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (~wb_ok),
    .d     (wb_d),
    .q     (wb_q)
  );

  always_comb begin
    RegWrite_W  = wb_q.reg_write;
    MemtoReg_W  = wb_q.mem_to_reg;
    rd_W        = wb_q.rd;
    readData_W  = wb_q.read_data;
    aluResult_W = wb_q.alu_result;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a random
// instruction stream, compared against an instruction-level reference model.
module tb_mem_stage;
  import lived_pkg::*;

  localparam int unsigned N  = 64;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, flush_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [4:0]   rd_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         zero_E;
  logic         dm_req, dm_we;
  logic [N-1:0] dm_addr, dm_wdata;
  logic         dm_ack;
  logic [N-1:0] dm_rdata;
  logic         stall_M, PCSrc_M, fault_M, RegWrite_W, MemtoReg_W;
  logic [N-1:0] PCBranch_M, readData_W, aluResult_W;
  logic [4:0]   rd_W;

  always #5 clk = ~clk;

  mem_stage #(.N(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_E     (valid_E),
    .flush_E     (flush_E),
    .Branch_E    (Branch_E),
    .MemRead_E   (MemRead_E),
    .MemWrite_E  (MemWrite_E),
    .RegWrite_E  (RegWrite_E),
    .MemtoReg_E  (MemtoReg_E),
    .rd_E        (rd_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .PCBranch_E  (PCBranch_E),
    .zero_E      (zero_E),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .stall_M     (stall_M),
    .PCSrc_M     (PCSrc_M),
    .PCBranch_M  (PCBranch_M),
    .fault_M     (fault_M),
    .RegWrite_W  (RegWrite_W),
    .MemtoReg_W  (MemtoReg_W),
    .rd_W        (rd_W),
    .readData_W  (readData_W),
    .aluResult_W (aluResult_W)
  );

  // One instruction plus the memory behaviour it will see: ack arrives after
  // 'lat' cycles in MEM (0 = same cycle), returning 'rdat'.
  typedef struct {
    logic         v, fl, br, mr, mw, rw, m2r, z;
    logic [4:0]   rd;
    logic [N-1:0] alu, wd, pcb, rdat;
    int           lat;
  } ins_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic br, input logic mr, input logic mw,
                              input logic rw, input logic z, input logic [4:0] rd,
                              input logic [N-1:0] alu, input logic [N-1:0] wd,
                              input logic [N-1:0] pcb, input logic [N-1:0] rdat, input int lat);
    ins_t r;
    r.v = v; r.fl = 1'b0; r.br = br; r.mr = mr; r.mw = mw; r.rw = rw; r.m2r = mr; r.z = z;
    r.rd = rd; r.alu = alu; r.wd = wd; r.pcb = pcb; r.rdat = rdat; r.lat = lat;
    return r;
  endfunction

  function automatic ins_t rand_ins();
    ins_t r;
    int kind, p;
    logic [N-1:0] a;
    kind = int'($urandom_range(0, 5));
    a = {$urandom, $urandom};
    if ($urandom_range(0, 5) != 0) a[2:0] = 3'b000;
    p = int'($urandom_range(0, 19));
    r = mk($urandom_range(0, 7) != 0, kind == 4, kind == 1 || kind == 3, kind == 2 || kind == 3,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
           a, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           p < 10 ? 0 : (p < 18 ? int'($urandom_range(1, 4)) : int'($urandom_range(14, 19))));
    r.m2r = 1'($urandom_range(0, 1));
    r.fl  = ($urandom_range(0, 9) == 0);
    return r;
  endfunction

  // Reference state: instruction sitting in MEM and how long it has been there,
  // plus the expected MEM/WB contents and fault flag.
  ins_t         m;
  int           age;
  logic         fault_e, wb_rw, wb_m2r;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_rdata, wb_alu;

  task automatic model_reset();
    m = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0, '0, 0);
    age = 0; fault_e = 1'b0;
    wb_rw = 1'b0; wb_m2r = 1'b0; wb_rd = 5'd0; wb_rdata = '0; wb_alu = '0;
  endtask

  // One clock: check registered outputs, drive the next inputs, check the
  // combinational outputs, then advance the model across the coming edge.
  task automatic step(input ins_t e, input logic rst);
    logic memop, mis, done, abort, stall, pcsrc, ack, req;
    logic [N-1:0] rdata;
    @(negedge clk);
    check("RegWrite_W",  64'(RegWrite_W), 64'(wb_rw));
    check("MemtoReg_W",  64'(MemtoReg_W), 64'(wb_m2r));
    check("rd_W",        64'(rd_W),       64'(wb_rd));
    check("readData_W",  readData_W,      wb_rdata);
    check("aluResult_W", aluResult_W,     wb_alu);
    check("fault_M",     64'(fault_M),    64'(fault_e));

    memop = m.v & (m.mr | m.mw);
    mis   = memop & (m.alu[2:0] != 3'b000);
    done  = memop & ~mis & (age == m.lat);
    abort = memop & ~mis & ~done & (age >= int'(TO));
    stall = memop & ~mis & ~done & ~abort;
    req   = memop & ~mis & ~abort;
    pcsrc = m.v & m.br & m.z & ~stall;
    ack   = (memop & ~mis) ? done : ($urandom_range(0, 3) == 0);
    rdata = done ? m.rdat : {$urandom, $urandom};

    reset = rst; dm_ack = ack; dm_rdata = rdata;
    valid_E = e.v; flush_E = e.fl | pcsrc; Branch_E = e.br; MemRead_E = e.mr;
    MemWrite_E = e.mw; RegWrite_E = e.rw; MemtoReg_E = e.m2r; zero_E = e.z; rd_E = e.rd;
    aluResult_E = e.alu; writeData_E = e.wd; PCBranch_E = e.pcb;
    #1;
    check("dm_req",     64'(dm_req),  64'(req));
    check("dm_we",      64'(dm_we),   64'(req & m.mw));
    check("dm_addr",    dm_addr,      m.alu);
    check("dm_wdata",   dm_wdata,     m.wd);
    check("stall_M",    64'(stall_M), 64'(stall));
    check("PCSrc_M",    64'(PCSrc_M), 64'(pcsrc));
    check("PCBranch_M", PCBranch_M,   m.pcb);

    if (!rst) begin
      model_reset();
    end else begin
      fault_e = fault_e | mis | abort;
      if (m.v & ~stall & ~mis & ~abort) begin
        wb_rw = m.rw; wb_m2r = m.m2r; wb_rd = m.rd; wb_alu = m.alu;
        wb_rdata = (m.mr & ~m.mw) ? rdata : '0;
      end else begin
        wb_rw = 1'b0; wb_m2r = 1'b0; wb_rd = 5'd0; wb_rdata = '0; wb_alu = '0;
      end
      if (stall) begin
        age++;
      end else begin
        m = e;
        m.v = e.v & ~(e.fl | pcsrc);
        age = 0;
      end
    end
  endtask

  ins_t bub, ld40, ld100, st08, alu, ldto, cbz, victim, ldmis;

  initial begin
    reset = 1'b0; valid_E = 1'b0; flush_E = 1'b0; Branch_E = 1'b0; MemRead_E = 1'b0;
    MemWrite_E = 1'b0; RegWrite_E = 1'b0; MemtoReg_E = 1'b0; rd_E = 5'd0; zero_E = 1'b0;
    aluResult_E = '0; writeData_E = '0; PCBranch_E = '0; dm_ack = 1'b0; dm_rdata = '0;
    model_reset();

    bub    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0, '0, 0);
    ld40   = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 64'h40,  '0, '0, 64'h55, 30);
    ld100  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 64'h100, '0, '0, 64'hDEAD, 3);
    st08   = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h8, 64'h1234, '0, '0, 0);
    alu    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 64'h77,  '0, '0, '0, 0);
    ldto   = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 64'h180, '0, '0, '0, 99);
    cbz    = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, '0, '0, 64'h200, '0, 0);
    victim = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 64'h44,  '0, '0, '0, 0);
    ldmis  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 64'hC,   '0, '0, '0, 0);

    // Reset state, then a load aborted by reset while waiting.
    step(bub, 1'b0);
    step(bub, 1'b1);
    step(ld40, 1'b1);
    repeat (3) step(bub, 1'b1);
    step(bub, 1'b0);
    repeat (2) step(bub, 1'b1);

    // Three-cycle load, zero-wait store followed by an ALU op, timeout.
    step(ld100, 1'b1);
    repeat (6) step(bub, 1'b1);
    step(st08, 1'b1);
    step(alu, 1'b1);
    repeat (3) step(bub, 1'b1);
    step(ldto, 1'b1);
    repeat (20) step(bub, 1'b1);

    // Taken branch squashes the following instruction; then a misaligned load.
    step(bub, 1'b0);
    step(cbz, 1'b1);
    step(victim, 1'b1);
    repeat (2) step(bub, 1'b1);
    step(ldmis, 1'b1);
    repeat (3) step(bub, 1'b1);

    // Random stream with occasional resets.
    step(bub, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      step(rand_ins(), $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- LEGv8 pipeline memory-access stage, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and performs load/store through a variable-latency data-memory req/ack handshake, stalling upstream while waiting.
- Resolves branch redirect (PCSrc_M/PCBranch_M) and drives the MEM/WB register feeding writeback.

Parameters:
N, 64, datapath width
TIMEOUT, 16, max cycles waiting for dm_ack before abort (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
valid_E  in  1  execute stage holds a real instruction
flush_E  in  1  squash the instruction being captured from execute
Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E  in  1 each  control from execute
rd_E  in  5  destination register
aluResult_E, writeData_E, PCBranch_E  in  N each  execute results
zero_E  in  1  ALU zero flag
dm_req  out  1  data-memory request
dm_we  out  1  1 = store, 0 = load
dm_addr, dm_wdata  out  N each  address/store data
dm_ack  in  1  memory completes request this cycle
dm_rdata  in  N  load data, valid when dm_ack=1
stall_M  out  1  hold fetch/decode/execute and EX/MEM register
PCSrc_M  out  1  take branch
PCBranch_M  out  N  branch target
fault_M  out  1  sticky: misaligned access or timeout
RegWrite_W, MemtoReg_W  out  1 each  MEM/WB control
rd_W  out  5  MEM/WB destination
readData_W, aluResult_W  out  N each  MEM/WB data

Behaviour:
- Reset (reset=0 at a rising edge): every register and output goes to 0, including valid_M, all MEM/WB fields, fault_M and timeout counter; FSM goes to IDLE. This also applies mid-transaction: request dropped, nothing written back.
- EX/MEM capture: when stall_M=0, the register loads all *_E inputs; valid_M <= valid_E & ~flush_E. When stall_M=1, it holds.
- memop = valid_M & (MemRead_M | MemWrite_M). MemRead and MemWrite both set: treated as store.
- Misaligned: memop & dm_addr[2:0]!=0 -> no request, fault_M<=1, bubble into MEM/WB, no stall.
- FSM IDLE:
  - Aligned memop -> dm_req=1 combinationally, dm_addr=aluResult_M, dm_wdata=writeData_M, dm_we=MemWrite_M.
  - dm_ack same cycle -> completes, no stall.
  - Otherwise stall_M=1 and next state WAIT with counter=1.
- FSM WAIT:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable; stall_M=1 until dm_ack.
  - On dm_ack: stall_M=0 that cycle, next state IDLE.
  - If counter reaches TIMEOUT without ack: abort, dm_req=0, fault_M<=1, bubble into MEM/WB, stall_M=0, next state IDLE.
  - Otherwise counter increments.
- dm_ack outside a request is ignored. With no request, dm_addr/dm_wdata carry the EX/MEM values and dm_we=0.
- MEM/WB: loads every cycle.
  - Completed or non-memory valid instruction -> RegWrite_W=RegWrite_M, MemtoReg_W=MemtoReg_M, rd_W=rd_M, aluResult_W=aluResult_M, readData_W=dm_rdata (load) or 0.
  - While stalled, invalid, or aborted -> bubble (RegWrite_W=0, all other MEM/WB fields 0).
- Branch: PCSrc_M = valid_M & Branch_M & zero_M & ~stall_M, combinational; PCBranch_M = PCBranch_M register. Upstream asserts flush_E on PCSrc_M.
- Latency: one cycle from execute into the EX/MEM register; MEM/WB valid one cycle after completion. Zero-wait memory gives one instruction per cycle.

Decomposition:
- Shared package (lived_pkg):
  - Typedef mem_state_t {IDLE, WAIT}.
  - Packed struct ex_mem_t (control bits, rd, three N-bit data fields).
  - Packed struct mem_wb_t.
  - Constants DM_ALIGN_BITS=3 and MEM_TIMEOUT_DEF=16.
- One sub-module: flopr_en_clr, an N-bit register with enable, synchronous active-low reset and clear, used for EX/MEM and MEM/WB.

Test Plan:
- Reset asserted mid-WAIT (load to 0x40 in flight) -> next cycle dm_req=0, stall_M=0, RegWrite_W=0, fault_M=0.
- Load to 0x100, rd=5, dm_ack after 3 cycles with rdata=0xDEAD -> stall_M high 3 cycles, dm_addr held 0x100; next cycle readData_W=0xDEAD, rd_W=5, RegWrite_W=1.
- Store writeData=0x1234 to 0x08, ack same cycle -> dm_req=1, dm_we=1, no stall; back-to-back ALU op proceeds next cycle.
- Load to 0x0C -> no dm_req, fault_M=1, RegWrite_W=0.
- Load, no ack for TIMEOUT=16 cycles -> stall ends after cycle 16, fault_M=1, bubble written back.
- CBZ with Branch=1, zero=1, PCBranch=0x200 -> PCSrc_M=1, PCBranch_M=0x200; the instruction captured with flush_E=1 enters as valid_M=0.
